// File: rtl/cu_vertex_cache_read_responder.sv
// Responder for compute-unit cacheline read commands.
// Serves hits from a direct-mapped vertex line cache. On a miss it issues one
// memory read, fills the line from the returned halves and then forwards them.
// Only one command is in flight at a time.
// Optional: define VERTEX_CACHE_STATS_EN to add saturating hit/miss counters.
module cu_vertex_cache_read_responder #(
  parameter int ADDR_W    = 64,
  parameter int TAG_W     = 8,
  parameter int HALF_W    = 512,
  parameter int RSP_W     = 8,
  parameter int NUM_LINES = 16
) (
  input  logic              clock,
  input  logic              rstn_in,
  input  logic              enabled_in,
  input  logic              flush_in,
  input  logic              cmd_valid_in,
  output logic              cmd_ready_out,
  input  logic [ADDR_W-1:0] cmd_addr_in,
  input  logic [TAG_W-1:0]  cmd_tag_in,
  output logic              mem_cmd_valid_out,
  input  logic              mem_cmd_ready_in,
  output logic [ADDR_W-1:0] mem_cmd_addr_out,
  output logic [TAG_W-1:0]  mem_cmd_tag_out,
  input  logic              mem_data_0_valid_in,
  input  logic              mem_data_1_valid_in,
  input  logic [HALF_W-1:0] mem_data_0_in,
  input  logic [HALF_W-1:0] mem_data_1_in,
  input  logic              mem_rsp_valid_in,
  input  logic [RSP_W-1:0]  mem_rsp_code_in,
  output logic              data_0_valid_out,
  output logic              data_1_valid_out,
  output logic [HALF_W-1:0] data_0_out,
  output logic [HALF_W-1:0] data_1_out,
  output logic [TAG_W-1:0]  data_tag_out,
  output logic              rsp_valid_out,
  output logic [TAG_W-1:0]  rsp_tag_out,
  output logic [RSP_W-1:0]  rsp_code_out,
`ifdef VERTEX_CACHE_STATS_EN
  output logic [31:0]       hit_count_out,
  output logic [31:0]       miss_count_out,
`endif
  output logic              busy_out
);

  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int LINE_W = ADDR_W - 7;
  localparam int LTAG_W = LINE_W - IDX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_HIT_D0,
    S_HIT_D1,
    S_MISS_REQ,
    S_MISS_WAIT,
    S_MISS_FWD,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  // Latched command and miss bookkeeping
  logic [LINE_W-1:0] line_q;
  logic [TAG_W-1:0]  tag_q;
  logic [RSP_W-1:0]  code_q;
  logic              got0_q, got1_q, got_rsp_q;
  logic [HALF_W-1:0] buf0_q, buf1_q;

  // Cache storage; only the valid bits need a reset
  logic [NUM_LINES-1:0] valid_q;
  logic [LTAG_W-1:0]    ltag_mem [NUM_LINES];
  logic [HALF_W-1:0]    d0_mem   [NUM_LINES];
  logic [HALF_W-1:0]    d1_mem   [NUM_LINES];

  logic [IDX_W-1:0]  idx;
  logic [LTAG_W-1:0] ltag;
  logic              hit;
  logic              accept, do_flush, do_fill, lookup_hit, lookup_miss;
  logic              rsp_seen, h0_seen, h1_seen;
  logic [RSP_W-1:0]  code_seen;

  // The byte offset inside a line never affects the result
  logic unused_offset;
  assign unused_offset = ^cmd_addr_in[6:0];

  assign idx  = line_q[IDX_W-1:0];
  assign ltag = line_q[LINE_W-1:IDX_W];
  assign hit  = valid_q[idx] && (ltag_mem[idx] == ltag);

  // Miss completion looks at this cycle's pulses so same-cycle arrivals count
  assign rsp_seen  = got_rsp_q | mem_rsp_valid_in;
  assign code_seen = mem_rsp_valid_in ? mem_rsp_code_in : code_q;
  assign h0_seen   = got0_q | mem_data_0_valid_in;
  assign h1_seen   = got1_q | mem_data_1_valid_in;

  // State register
  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode and all outputs
  always_comb begin
    state_d           = state_q;
    cmd_ready_out     = 1'b0;
    mem_cmd_valid_out = 1'b0;
    mem_cmd_addr_out  = '0;
    mem_cmd_tag_out   = '0;
    data_0_valid_out  = 1'b0;
    data_1_valid_out  = 1'b0;
    data_0_out        = '0;
    data_1_out        = '0;
    data_tag_out      = '0;
    rsp_valid_out     = 1'b0;
    rsp_tag_out       = '0;
    rsp_code_out      = '0;
    accept            = 1'b0;
    do_flush          = 1'b0;
    do_fill           = 1'b0;
    lookup_hit        = 1'b0;
    lookup_miss       = 1'b0;
    busy_out          = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        cmd_ready_out = rstn_in & enabled_in & ~flush_in;
        do_flush      = flush_in;
        accept        = cmd_valid_in & rstn_in & enabled_in & ~flush_in;
        if (accept) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        lookup_hit  = hit;
        lookup_miss = ~hit;
        state_d     = hit ? S_HIT_D0 : S_MISS_REQ;
      end
      S_HIT_D0: begin
        data_0_valid_out = 1'b1;
        data_0_out       = d0_mem[idx];
        data_tag_out     = tag_q;
        state_d          = S_HIT_D1;
      end
      S_HIT_D1: begin
        data_1_valid_out = 1'b1;
        data_1_out       = d1_mem[idx];
        data_tag_out     = tag_q;
        state_d          = S_RESP;
      end
      S_MISS_REQ: begin
        mem_cmd_valid_out = 1'b1;
        mem_cmd_addr_out  = {line_q, 7'b0};
        mem_cmd_tag_out   = tag_q;
        if (mem_cmd_ready_in) state_d = S_MISS_WAIT;
      end
      S_MISS_WAIT: begin
        if (rsp_seen && ((code_seen != '0) || (h0_seen && h1_seen)))
          state_d = S_MISS_FWD;
      end
      S_MISS_FWD: begin
        // A good fill lands at this edge, so the second half is then
        // replayed from the cache through the hit path
        if (code_q == '0) begin
          do_fill          = 1'b1;
          data_0_valid_out = 1'b1;
          data_0_out       = buf0_q;
          data_tag_out     = tag_q;
          state_d          = S_HIT_D1;
        end else begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid_out = 1'b1;
        rsp_tag_out   = tag_q;
        rsp_code_out  = code_q;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Command latch, miss capture and cache valid bits
  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) begin
      line_q    <= '0;
      tag_q     <= '0;
      code_q    <= '0;
      got0_q    <= 1'b0;
      got1_q    <= 1'b0;
      got_rsp_q <= 1'b0;
      buf0_q    <= '0;
      buf1_q    <= '0;
      valid_q   <= '0;
    end else begin
      if (accept) begin
        line_q    <= cmd_addr_in[ADDR_W-1:7];
        tag_q     <= cmd_tag_in;
        code_q    <= '0;
        got0_q    <= 1'b0;
        got1_q    <= 1'b0;
        got_rsp_q <= 1'b0;
      end
      if (do_flush) valid_q <= '0;
      if (state_q == S_MISS_WAIT) begin
        if (mem_data_0_valid_in) begin
          buf0_q <= mem_data_0_in;
          got0_q <= 1'b1;
        end
        if (mem_data_1_valid_in) begin
          buf1_q <= mem_data_1_in;
          got1_q <= 1'b1;
        end
        if (mem_rsp_valid_in) begin
          code_q    <= mem_rsp_code_in;
          got_rsp_q <= 1'b1;
        end
      end
      if (do_fill) valid_q[idx] <= 1'b1;
    end
  end

  // Line tag and payload storage, written on a successful fill
  always_ff @(posedge clock) begin
    if (do_fill) begin
      ltag_mem[idx] <= ltag;
      d0_mem[idx]   <= buf0_q;
      d1_mem[idx]   <= buf1_q;
    end
  end

`ifdef VERTEX_CACHE_STATS_EN
  // Saturating lookup statistics, cleared by flush
  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) begin
      hit_count_out  <= '0;
      miss_count_out <= '0;
    end else if (do_flush) begin
      hit_count_out  <= '0;
      miss_count_out <= '0;
    end else begin
      if (lookup_hit && (hit_count_out != '1))   hit_count_out  <= hit_count_out + 32'd1;
      if (lookup_miss && (miss_count_out != '1)) miss_count_out <= miss_count_out + 32'd1;
    end
  end
`else
  logic unused_lookup;
  assign unused_lookup = lookup_hit ^ lookup_miss;
`endif

endmodule

// File: tb/tb_cu_vertex_cache_read_responder.sv
// Self-checking bench for cu_vertex_cache_read_responder: a table of directed
// commands, hand-written flush/reset/enable sequences, then randomized
// commands checked against a line-ownership model of the cache.
module tb_cu_vertex_cache_read_responder;

  logic         clock = 1'b0;
  logic         rstn_in;
  logic         enabled_in;
  logic         flush_in;
  logic         cmd_valid_in;
  logic         cmd_ready_out;
  logic [63:0]  cmd_addr_in;
  logic [7:0]   cmd_tag_in;
  logic         mem_cmd_valid_out;
  logic         mem_cmd_ready_in;
  logic [63:0]  mem_cmd_addr_out;
  logic [7:0]   mem_cmd_tag_out;
  logic         mem_data_0_valid_in, mem_data_1_valid_in;
  logic [511:0] mem_data_0_in, mem_data_1_in;
  logic         mem_rsp_valid_in;
  logic [7:0]   mem_rsp_code_in;
  logic         data_0_valid_out, data_1_valid_out;
  logic [511:0] data_0_out, data_1_out;
  logic [7:0]   data_tag_out;
  logic         rsp_valid_out;
  logic [7:0]   rsp_tag_out;
  logic [7:0]   rsp_code_out;
  logic         busy_out;

  cu_vertex_cache_read_responder #(
    .ADDR_W(64), .TAG_W(8), .HALF_W(512), .RSP_W(8), .NUM_LINES(16)
  ) dut (
    .clock(clock), .rstn_in(rstn_in), .enabled_in(enabled_in), .flush_in(flush_in),
    .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out),
    .cmd_addr_in(cmd_addr_in), .cmd_tag_in(cmd_tag_in),
    .mem_cmd_valid_out(mem_cmd_valid_out), .mem_cmd_ready_in(mem_cmd_ready_in),
    .mem_cmd_addr_out(mem_cmd_addr_out), .mem_cmd_tag_out(mem_cmd_tag_out),
    .mem_data_0_valid_in(mem_data_0_valid_in), .mem_data_1_valid_in(mem_data_1_valid_in),
    .mem_data_0_in(mem_data_0_in), .mem_data_1_in(mem_data_1_in),
    .mem_rsp_valid_in(mem_rsp_valid_in), .mem_rsp_code_in(mem_rsp_code_in),
    .data_0_valid_out(data_0_valid_out), .data_1_valid_out(data_1_valid_out),
    .data_0_out(data_0_out), .data_1_out(data_1_out), .data_tag_out(data_tag_out),
    .rsp_valid_out(rsp_valid_out), .rsp_tag_out(rsp_tag_out), .rsp_code_out(rsp_code_out),
    .busy_out(busy_out)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Cache model: which line address owns each index, and that line's halves
  logic [56:0]  owner [int];
  logic [511:0] own_d0 [int];
  logic [511:0] own_d1 [int];

  // Memory return orderings: per step, bit0=data_0, bit1=data_1, bit2=rsp
  int steps [5][3];

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  tag;
    logic [7:0]  code;
    int          order;
    int          rdy;
    int          exp_miss;
  } vec_t;
  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_wide(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic gen_half(output logic [511:0] v);
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
  endtask

  function automatic int model_miss(input logic [63:0] addr);
    int i;
    i = int'(addr[10:7]);
    if (owner.exists(i) && owner[i] == addr[63:7]) return 0;
    return 1;
  endfunction

  task automatic clear_mem_inputs();
    mem_cmd_ready_in    = 1'b0;
    mem_data_0_valid_in = 1'b0;
    mem_data_1_valid_in = 1'b0;
    mem_rsp_valid_in    = 1'b0;
  endtask

  // Issue one command at a negedge with the DUT idle, play memory, check all
  // observed outputs and return at the negedge after the response.
  task automatic run_cmd(input logic [63:0] addr, input logic [7:0] tag, input logic [7:0] code,
                         input int order, input int rdy, input int exp_miss, input string name);
    logic [511:0] g0, g1, e0, e1, d0v, d1v;
    logic [7:0]   rtag, rcode, exp_code;
    int d0_k, d1_k, rsp_k, mreq, mphase, wait_cnt, idx;
    bit prev_mcv;
    gen_half(g0);
    gen_half(g1);
    d0_k = -1; d1_k = -1; rsp_k = -1; mreq = 0; mphase = 0; wait_cnt = 0; prev_mcv = 1'b0;
    d0v = '0; d1v = '0; rtag = '0; rcode = '0;
    idx = int'(addr[10:7]);
    mem_data_0_in   = g0;
    mem_data_1_in   = g1;
    mem_rsp_code_in = code;

    cmd_valid_in = 1'b1;
    cmd_addr_in  = addr;
    cmd_tag_in   = tag;
    #1 chk({name, ".cmd_ready"}, cmd_ready_out, 1);
    @(posedge clock);
    #1 cmd_valid_in = 1'b0;
    enabled_in = 1'($urandom_range(0, 1));

    for (int k = 1; k <= 200; k++) begin
      @(negedge clock);
      clear_mem_inputs();
      if (data_0_valid_out) begin
        d0_k = k; d0v = data_0_out;
        chk({name, ".data_tag0"}, data_tag_out, tag);
      end
      if (data_1_valid_out) begin
        d1_k = k; d1v = data_1_out;
        chk({name, ".data_tag1"}, data_tag_out, tag);
      end
      if (rsp_valid_out) begin
        rsp_k = k; rtag = rsp_tag_out; rcode = rsp_code_out;
        break;
      end
      if (mphase >= 1 && mphase <= 3) begin
        mem_data_0_valid_in = steps[order][mphase-1][0];
        mem_data_1_valid_in = steps[order][mphase-1][1];
        mem_rsp_valid_in    = steps[order][mphase-1][2];
        mphase++;
      end
      if (mem_cmd_valid_out) begin
        if (!prev_mcv) begin
          mreq++;
          wait_cnt = 0;
        end
        chk({name, ".mem_addr"}, mem_cmd_addr_out, {addr[63:7], 7'b0});
        chk({name, ".mem_tag"}, mem_cmd_tag_out, tag);
        if (wait_cnt == rdy) begin
          mem_cmd_ready_in = 1'b1;
          mphase = 1;
        end else begin
          wait_cnt++;
        end
      end
      prev_mcv = mem_cmd_valid_out;
    end
    clear_mem_inputs();

    chk({name, ".completed"}, rsp_k > 0, 1);
    chk({name, ".mem_requests"}, mreq, exp_miss);
    exp_code = exp_miss ? code : 8'h00;
    if (exp_code == 8'h00) begin
      if (exp_miss) begin
        e0 = g0; e1 = g1;
      end else begin
        e0 = own_d0[idx]; e1 = own_d1[idx];
      end
      chk_wide({name, ".data_0"}, d0v, e0);
      chk_wide({name, ".data_1"}, d1v, e1);
      chk({name, ".d1_after_d0"}, d1_k - d0_k, 1);
      chk({name, ".rsp_after_d1"}, rsp_k - d1_k, 1);
      if (!exp_miss) chk({name, ".hit_d0_latency"}, d0_k, 2);
    end else begin
      chk({name, ".no_data"}, (d0_k < 0) && (d1_k < 0), 1);
    end
    chk({name, ".rsp_tag"}, rtag, tag);
    chk({name, ".rsp_code"}, rcode, exp_code);

    @(negedge clock);
    chk({name, ".idle_after"}, {busy_out, rsp_valid_out}, 0);
    enabled_in = 1'b1;

    if (exp_miss && code == 8'h00) begin
      owner[idx]  = addr[63:7];
      own_d0[idx] = g0;
      own_d1[idx] = g1;
    end
  endtask

  initial begin
    steps[0] = '{1, 2, 4};
    steps[1] = '{2, 1, 4};
    steps[2] = '{3, 4, 0};
    steps[3] = '{4, 1, 2};
    steps[4] = '{7, 0, 0};

    //            addr               tag    code   ord rdy miss
    vecs[0] = '{64'h1000,          8'h05, 8'h00, 1, 0, 1};  // cold miss, data_1 first
    vecs[1] = '{64'h1040,          8'h06, 8'h00, 0, 0, 0};  // same line hit
    vecs[2] = '{64'h1800,          8'h07, 8'h00, 0, 1, 1};  // same index, evicts
    vecs[3] = '{64'h1000,          8'h08, 8'h00, 2, 0, 1};  // evicted, misses again
    vecs[4] = '{64'h2080,          8'h09, 8'h03, 3, 0, 1};  // error, rsp before data
    vecs[5] = '{64'h2080,          8'h0A, 8'h00, 4, 0, 1};  // retry misses, all at once
    vecs[6] = '{64'h20C0,          8'h0B, 8'h00, 0, 0, 0};  // hit on filled line
    vecs[7] = '{64'h3100,          8'h0C, 8'h00, 0, 5, 1};  // 5-cycle request backpressure
    vecs[8] = '{64'hFFFF_FFFF_FFFF_FF80, 8'hFF, 8'h00, 3, 2, 1};  // top line, rsp first

    rstn_in = 1'b0; enabled_in = 1'b1; flush_in = 1'b0;
    cmd_valid_in = 1'b0; cmd_addr_in = '0; cmd_tag_in = '0;
    mem_data_0_in = '0; mem_data_1_in = '0; mem_rsp_code_in = '0;
    clear_mem_inputs();

    repeat (3) @(negedge clock);
    chk("reset.cmd_ready", cmd_ready_out, 0);
    chk("reset.valids", {busy_out, mem_cmd_valid_out, data_0_valid_out, data_1_valid_out, rsp_valid_out}, 0);
    chk("reset.fields", {data_tag_out, rsp_tag_out, rsp_code_out, mem_cmd_tag_out}, 0);
    chk("reset.mem_addr", mem_cmd_addr_out, 0);
    rstn_in = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 9; i++)
      run_cmd(vecs[i].addr, vecs[i].tag, vecs[i].code, vecs[i].order, vecs[i].rdy,
              vecs[i].exp_miss, $sformatf("vec%0d", i));

    // Disabled: command is not taken
    enabled_in = 1'b0;
    cmd_valid_in = 1'b1; cmd_addr_in = 64'h1000; cmd_tag_in = 8'h44;
    #1 chk("disabled.cmd_ready", cmd_ready_out, 0);
    @(negedge clock);
    chk("disabled.busy", busy_out, 0);
    cmd_valid_in = 1'b0; enabled_in = 1'b1;

    // Flush in idle invalidates everything, cached line then misses
    flush_in = 1'b1;
    #1 chk("flush.cmd_ready", cmd_ready_out, 0);
    @(negedge clock);
    flush_in = 1'b0;
    chk("flush.busy", busy_out, 0);
    owner.delete(); own_d0.delete(); own_d1.delete();
    run_cmd(64'h1000, 8'h21, 8'h00, 0, 0, 1, "post_flush");
    run_cmd(64'h2080, 8'h22, 8'h00, 1, 0, 1, "post_flush2");

    // Reset while waiting on memory abandons the command
    begin
      bit seen_req, stray;
      seen_req = 1'b0; stray = 1'b0;
      cmd_valid_in = 1'b1; cmd_addr_in = 64'h4000; cmd_tag_in = 8'h33;
      @(posedge clock);
      #1 cmd_valid_in = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clock);
        if (mem_cmd_valid_out) begin
          seen_req = 1'b1;
          break;
        end
      end
      chk("rst_mid.req_seen", seen_req, 1);
      mem_cmd_ready_in = 1'b1;
      @(negedge clock);
      mem_cmd_ready_in = 1'b0;
      mem_data_0_valid_in = 1'b1;
      @(negedge clock);
      mem_data_0_valid_in = 1'b0;
      rstn_in = 1'b0;
      #1 chk("rst_mid.busy", busy_out, 0);
      @(negedge clock);
      rstn_in = 1'b1;
      mem_data_0_valid_in = 1'b1; mem_data_1_valid_in = 1'b1; mem_rsp_valid_in = 1'b1;
      @(negedge clock);
      clear_mem_inputs();
      for (int k = 0; k < 6; k++) begin
        if (data_0_valid_out || data_1_valid_out || rsp_valid_out || busy_out || mem_cmd_valid_out)
          stray = 1'b1;
        @(negedge clock);
      end
      chk("rst_mid.no_output", stray, 0);
      owner.delete(); own_d0.delete(); own_d1.delete();
      run_cmd(64'h2080, 8'h34, 8'h00, 0, 0, 1, "post_reset");
    end

    // Randomized commands over a small address pool to force hits and evictions
    for (int n = 0; n < 80; n++) begin
      logic [63:0] a;
      logic [7:0]  c;
      a = ({57'($urandom_range(0, 2)), 4'($urandom_range(0, 3))} << 7) | 64'($urandom_range(0, 127));
      a = a + 64'h0008_0000;
      c = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      run_cmd(a, 8'($urandom), c, $urandom_range(0, 4), $urandom_range(0, 3),
              model_miss(a), $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cu_vertex_cache_read_responder.md
Name: cu_vertex_cache_read_responder

Overview:
- Responder end of the compute-unit read-command path: accepts cacheline read commands from vertex CUs and returns the two data halves plus a completion response.
- Serves hits from a small direct-mapped vertex line cache.
- On a miss, issues one read to the memory side, fills the cache from the returned halves, then forwards them.
- Blocking design: one command in flight at a time.

Parameters:
- ADDR_W, 64, byte address width.
- TAG_W, 8, command tag width.
- HALF_W, 512, width of one 64-byte cacheline half.
- RSP_W, 8, response code width; code 0 = DONE.
- NUM_LINES, 16, cache lines (power of 2, min 2); line = 128 B.

Ports:
- clock  in  1  clock
- rstn_in  in  1  asynchronous active-low reset
- enabled_in  in  1  block enable; when low, no new command accepted
- flush_in  in  1  invalidate all lines (level; sampled in IDLE)
- cmd_valid_in  in  1  read command valid
- cmd_ready_out  out  1  command accepted when valid&ready
- cmd_addr_in  in  ADDR_W  read byte address
- cmd_tag_in  in  TAG_W  command tag
- mem_cmd_valid_out  out  1  miss read request valid
- mem_cmd_ready_in  in  1  memory side accepts request
- mem_cmd_addr_out  out  ADDR_W  line-aligned miss address
- mem_cmd_tag_out  out  TAG_W  tag of pending command
- mem_data_0_valid_in / mem_data_1_valid_in  in  1  returned half valid
- mem_data_0_in / mem_data_1_in  in  HALF_W  returned half payload
- mem_rsp_valid_in  in  1  memory response valid
- mem_rsp_code_in  in  RSP_W  memory response code
- data_0_valid_out / data_1_valid_out  out  1  half valid (single-cycle pulse)
- data_0_out / data_1_out  out  HALF_W  half payload
- data_tag_out  out  TAG_W  tag accompanying data pulses
- rsp_valid_out  out  1  completion pulse
- rsp_tag_out  out  TAG_W  completion tag
- rsp_code_out  out  RSP_W  completion code
- busy_out  out  1  state != IDLE

Behaviour:
- Reset (async): all valid bits cleared, all cache valid bits cleared, payload/tag/code outputs 0, cmd_ready_out 0, FSM to IDLE.
- Reset mid-transaction abandons the command with no response; a later mem_* pulse is ignored in IDLE.
- Address split: offset = addr[6:0] (ignored), index = addr[7 +: log2(NUM_LINES)], line tag = remaining upper bits.
- mem_cmd_addr_out = {addr[ADDR_W-1:7], 7'b0}.
- cmd_ready_out = 1 only in IDLE with enabled_in=1 and flush_in=0.
- FSM states and transitions:
  - IDLE: flush_in=1 → clear all cache valid bits in one cycle, stay IDLE. Otherwise, on accept latch addr/tag → LOOKUP.
  - LOOKUP (1 cycle): hit → HIT_D0; miss → MISS_REQ.
  - HIT_D0: pulse data_0 from cache → HIT_D1.
  - HIT_D1: pulse data_1 → RESP with code 0.
  - MISS_REQ: hold mem_cmd_valid_out=1 with stable addr/tag until mem_cmd_ready_in → MISS_WAIT.
  - MISS_WAIT: capture halves in either order or the same cycle, set per-half flags; a repeated half overwrites. Capture mem_rsp_code_in on mem_rsp_valid_in. Leave when the response is captured and (code≠0, or both halves captured) → MISS_FWD. Response may arrive before data.
  - MISS_FWD: code=0 → write line (both halves, tag, valid=1), pulse data_0 → next cycle pulse data_1 → RESP. Code≠0 → no fill, no data pulses, old line contents untouched → RESP.
  - RESP: pulse rsp_valid_out with latched tag/code → IDLE.
- Hit latency: accept at cycle N; data_0 at N+2, data_1 at N+3, response at N+4.
- Outputs carry no backpressure. Data pulses always precede the response.
- Same-index miss evicts the old line (no write-back; the cache is read-only).
- enabled_in going low mid-transaction does not abort; the current command completes.

Optional Feature:
- Macro VERTEX_CACHE_STATS_EN. When defined, adds outputs hit_count_out and miss_count_out, 32 bits each.
  - hit_count_out increments at LOOKUP on a hit; miss_count_out increments at LOOKUP on a miss.
  - Both saturate at 0xFFFFFFFF; both cleared by reset and by flush.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Cold miss: cmd addr 0x1000 tag 0x05; mem returns data_1=A1 then data_0=A0, rsp 0 → mem_cmd_addr 0x1000 tag 0x05; data_0=A0 then data_1=A1 on consecutive cycles; rsp tag 0x05 code 0.
- Hit: repeat addr 0x1040 (same line) tag 0x06 → no mem_cmd; data_0 at N+2, data_1 at N+3, rsp code 0 at N+4.
- Eviction: with NUM_LINES=16, read 0x1000 then 0x1800 (same index 0) then 0x1000 → three mem requests.
- Error: miss with rsp code 0x03 before any data → no data pulses, rsp code 0x03; a retry of the same address misses again.
- Flush and backpressure: hold mem_cmd_ready_in low 5 cycles → mem_cmd stays valid and stable. Then flush in IDLE and re-read a cached address → miss. With stats enabled, counters read 0 after flush.
- Reset mid MISS_WAIT: a late mem_data/rsp pulse produces no output; busy_out=0; the next command misses.
